// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - binary to 3-digit BCD sequencer with multiplexed common-anode scan
// Optional feature macro: SEG7_LZB_EN (leading-zero blanking on the scanned anode enables)
module seg7_scan_ctrl #(
  parameter int WIDTH    = 10,
  parameter int SCAN_DIV = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_ready,
  output logic [3:0]       o_hundreds,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones,
  output logic [3:0]       o_digit,
  output logic [2:0]       o_an,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_bin;
  logic [11:0]      r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_pend;

  logic [3:0]       r_hundreds;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_ovf;

  logic [PW-1:0]    r_pre;
  logic [1:0]       r_slot;

  logic             w_xfer;
  logic             w_last_shift;
  logic [11:0]      w_adj;
  logic             w_big;
  logic             w_tc;
  logic             w_blank_h;
  logic             w_blank_t;

  assign w_xfer       = (r_state == S_IDLE) && i_valid;
  assign w_last_shift = (r_cnt == CW'(WIDTH - 1));
  assign w_big        = (32'(i_value) > 32'd999);
  assign w_tc         = (r_pre == PW'(SCAN_DIV - 1));

  // Add-3 correction applied to every BCD nibble that is 5 or more before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < 3; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5) begin
        w_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic: IDLE -> CONV for exactly WIDTH cycles -> LOAD for one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_xfer) w_next = S_CONV;
      S_CONV: if (w_last_shift) w_next = S_LOAD;
      S_LOAD: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Conversion datapath: capture on transfer, then shift {bcd,bin} left once per CONV cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_bin      <= i_value;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_big;
          end
        end
        S_CONV: begin
          {r_bcd, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + CW'(1);
          // A bit leaving the hundreds nibble only happens for values already above 999
          r_ovf_pend     <= r_ovf_pend | w_adj[11];
        end
        default: ;
      endcase
    end
  end

  // Display latches: all three digits and the overflow flag change together in LOAD
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hundreds <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_ovf      <= 1'b0;
    end else if (r_state == S_LOAD) begin
      if (r_ovf_pend) begin
        r_hundreds <= 4'hF;
        r_tens     <= 4'hF;
        r_ones     <= 4'hF;
        r_ovf      <= 1'b1;
      end else begin
        r_hundreds <= r_bcd[11:8];
        r_tens     <= r_bcd[7:4];
        r_ones     <= r_bcd[3:0];
        r_ovf      <= 1'b0;
      end
    end
  end

  // Free-running scan prescaler and slot rotation, independent of the conversion FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre  <= '0;
      r_slot <= 2'd0;
    end else if (w_tc) begin
      r_pre  <= '0;
      r_slot <= (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
    end else begin
      r_pre  <= r_pre + PW'(1);
    end
  end

`ifdef SEG7_LZB_EN
  assign w_blank_h = !r_ovf && (r_hundreds == 4'd0);
  assign w_blank_t = !r_ovf && (r_hundreds == 4'd0) && (r_tens == 4'd0);
`else
  assign w_blank_h = 1'b0;
  assign w_blank_t = 1'b0;
`endif

  // Scan output decode from registered slot and digit state only
  always_comb begin
    o_an    = 3'b111;
    o_digit = 4'd0;
    case (r_slot)
      2'd0: begin
        o_an    = 3'b110;
        o_digit = r_ones;
      end
      2'd1: begin
        o_an    = w_blank_t ? 3'b111 : 3'b101;
        o_digit = r_tens;
      end
      2'd2: begin
        o_an    = w_blank_h ? 3'b111 : 3'b011;
        o_digit = r_hundreds;
      end
      default: begin
        o_an    = 3'b111;
        o_digit = 4'd0;
      end
    endcase
  end

  assign o_ready    = (r_state == S_IDLE);
  assign o_hundreds = r_hundreds;
  assign o_tens     = r_tens;
  assign o_ones     = r_ones;
  assign o_ovf      = r_ovf;

endmodule
